mmio_console: RTL and testbench
===============================

MMIO_CONSOLE -- requirements
Module: mmio_console

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (>=2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter CONSOLE_ADDR, default 32'hFFFF_FFF0, byte-push address.
REQ-004 SHALL have parameter STATUS_ADDR, default 32'hFFFF_FFF8, status-read address.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port MemWrite  input  1  CPU store strobe, one store per cycle.
REQ-008 SHALL have port DataAdr  input  32  CPU data address.
REQ-009 SHALL have port WriteData  input  32  CPU store data; bits [7:0] form the byte.
REQ-010 SHALL have port Ecall  input  1  CPU ECALL retire indication.
REQ-011 SHALL have port Ebreak  input  1  CPU EBREAK retire indication.
REQ-012 SHALL have port ReadData  output  32  status word, combinational.
REQ-013 SHALL have port tx  output  1  serial line, registered, idle high.
REQ-014 SHALL have port tx_busy  output  1  high when FIFO non-empty or serializer not IDLE.
REQ-015 SHALL have port overflow  output  1  sticky, byte dropped on full FIFO.
REQ-016 SHALL have port halted  output  1  sticky, Ecall or Ebreak seen.
REQ-017 SHALL have port done  output  1  registered, halted and fully drained.

Function
REQ-018 SHALL push WriteData[7:0] when MemWrite=1, DataAdr==CONSOLE_ADDR, halted=0.
REQ-019 SHALL accept a push when count<FIFO_DEPTH or a pop occurs in the same cycle; otherwise drop the byte and set overflow.
REQ-020 SHALL ignore stores to any other address.
REQ-021 SHALL drive ReadData={29'b0, overflow, tx_busy, full} when DataAdr==STATUS_ADDR, else 32'b0.
REQ-022 SHALL implement serializer states IDLE, START, DATA, STOP.
REQ-023 SHALL, in IDLE with FIFO non-empty, pop the head byte and enter START on the next edge.
REQ-024 SHALL drive tx=0 for CLKS_PER_BIT cycles in START, then 8 data bits LSB first of CLKS_PER_BIT cycles each in DATA, then tx=1 for CLKS_PER_BIT cycles in STOP, then return to IDLE.
REQ-025 SHALL make latency from a store edge into an empty idle console to first tx=0 exactly 2 cycles.
REQ-026 SHALL permit a pop in the STOP->IDLE cycle only on the following edge; back-to-back frames are separated by exactly one idle cycle at tx=1.
REQ-027 SHALL set halted on any edge where Ecall or Ebreak is 1; stores in that same cycle are still accepted.
REQ-028 SHALL assert done one cycle after halted=1, FIFO empty, and state IDLE all hold; it stays high until reset.
REQ-029 SHALL wrap FIFO pointers modulo FIFO_DEPTH with no lost or duplicated bytes.

Reset
REQ-030 SHALL, on reset, clear FIFO, counters, overflow, halted, and done, force state IDLE and tx=1, including mid-frame aborts.
REQ-031 SHALL ignore MemWrite, Ecall, and Ebreak in any cycle with reset=1.

Configuration
REQ-032 SHALL, with MMIO_CONSOLE_EXIT_EN defined, add parameter EXIT_ADDR default 32'hFFFF_FFF4 and output exit_code [31:0]; a store there while halted=0 latches WriteData and sets halted exactly as Ecall does.
REQ-033 SHALL, without MMIO_CONSOLE_EXIT_EN, omit exit_code and treat EXIT_ADDR stores as ignored.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-034 SHALL cover: store 0x41 to CONSOLE_ADDR -> tx low 2 cycles later; bits 1,0,0,0,0,0,1,0 each 4 cycles; stop high; frame 40 cycles.
REQ-035 SHALL cover: 9 stores 0x30..0x38 in consecutive cycles while idle -> first popped immediately, all 9 transmitted in order, overflow=0.
REQ-036 SHALL cover: 10 consecutive stores while a frame is in progress -> 8 bytes kept, overflow=1, status read returns 0x7 while full.
REQ-037 SHALL cover: 3 bytes queued, Ecall pulse -> halted next edge; later stores ignored; done rises 1 cycle after third stop bit ends.
REQ-038 SHALL cover: reset pulse during DATA of 0x55 -> tx=1, tx_busy=0, halted=0 next cycle; a following store 0x0A transmits cleanly.
REQ-039 SHALL cover, with MMIO_CONSOLE_EXIT_EN: store 0x2A to EXIT_ADDR -> exit_code=0x2A, halted=1, done after drain.

Source files
------------

// File: rtl/mmio_console.sv
// Memory-mapped transmit-only console: CPU stores feed a byte FIFO drained by an 8N1 serializer.
// Optional exit-code register at EXIT_ADDR is enabled by defining MMIO_CONSOLE_EXIT_EN.
module mmio_console #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [31:0] CONSOLE_ADDR = 32'hFFFF_FFF0,
`ifdef MMIO_CONSOLE_EXIT_EN
    parameter logic [31:0] EXIT_ADDR    = 32'hFFFF_FFF4,
`endif
    parameter logic [31:0] STATUS_ADDR  = 32'hFFFF_FFF8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        Ecall,
    input  logic        Ebreak,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        tx_busy,
    output logic        overflow,
    output logic        halted,
`ifdef MMIO_CONSOLE_EXIT_EN
    output logic [31:0] exit_code,
`endif
    output logic        done
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    state_e          state_q, state_d;
    logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            overflow_q, overflow_d;
    logic            halted_q, halted_d;
    logic            done_q, done_d;

    logic full, empty, pop, push_req, push, halt_req;

`ifdef MMIO_CONSOLE_EXIT_EN
    logic        exit_store;
    logic [31:0] exit_code_q, exit_code_d;
    assign exit_store  = MemWrite && (DataAdr == EXIT_ADDR) && !halted_q;
    assign exit_code_d = exit_store ? WriteData : exit_code_q;
    assign halt_req    = Ecall || Ebreak || exit_store;
    assign exit_code   = exit_code_q;
`else
    logic unused_wdata;
    assign unused_wdata = ^WriteData[31:8];
    assign halt_req     = Ecall || Ebreak;
`endif

    assign full     = (count_q == CountFull);
    assign empty    = (count_q == '0);
    assign pop      = (state_q == StIdle) && !empty;
    assign push_req = MemWrite && (DataAdr == CONSOLE_ADDR) && !halted_q;
    // A pop in the same cycle frees a slot, so a full FIFO can still take the byte.
    assign push     = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d    = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q || (push_req && full && !pop);
        halted_d   = halted_q || halt_req;
        done_d     = done_q || (halted_q && empty && (state_q == StIdle));
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    shift_d   = fifo_q[rd_ptr_q];
                    clk_cnt_d = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                clk_cnt_d = clk_cnt_q + CntW'(1);
                if (clk_cnt_q == CntMax) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                clk_cnt_d = clk_cnt_q + CntW'(1);
                if (clk_cnt_q == CntMax) begin
                    clk_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                clk_cnt_d = clk_cnt_q + CntW'(1);
                if (clk_cnt_q == CntMax) begin
                    clk_cnt_d = '0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The line follows the state one cycle late, giving the two-cycle store-to-start latency.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            overflow_q  <= 1'b0;
            halted_q    <= 1'b0;
            done_q      <= 1'b0;
`ifdef MMIO_CONSOLE_EXIT_EN
            exit_code_q <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            overflow_q  <= overflow_d;
            halted_q    <= halted_d;
            done_q      <= done_d;
`ifdef MMIO_CONSOLE_EXIT_EN
            exit_code_q <= exit_code_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_q[wr_ptr_q] <= WriteData[7:0];
        end
    end

    assign tx       = tx_q;
    assign tx_busy  = !empty || (state_q != StIdle);
    assign overflow = overflow_q;
    assign halted   = halted_q;
    assign done     = done_q;
    assign ReadData = (DataAdr == STATUS_ADDR) ? {29'b0, overflow_q, tx_busy, full} : 32'b0;

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console (CLKS_PER_BIT=4, FIFO_DEPTH=8): expected bytes are queued
// on each accepted store and popped by a line receiver that decodes every tx frame.
module tb_mmio_console;

    localparam logic [31:0] ConsoleAddr = 32'hFFFF_FFF0;
    localparam logic [31:0] ExitAddr    = 32'hFFFF_FFF4;
    localparam logic [31:0] StatusAddr  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        Ecall = 1'b0;
    logic        Ebreak = 1'b0;
    logic [31:0] ReadData;
    logic        tx, tx_busy, overflow, halted, done;
`ifdef MMIO_CONSOLE_EXIT_EN
    logic [31:0] exit_code;
`endif

    mmio_console #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .Ecall    (Ecall),
        .Ebreak   (Ebreak),
        .ReadData (ReadData),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .overflow (overflow),
        .halted   (halted),
`ifdef MMIO_CONSOLE_EXIT_EN
        .exit_code(exit_code),
`endif
        .done     (done)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [7:0] sb[$];
    int         starts[$];
    int         rx_frames = 0;
    logic       rx_active = 1'b0;
    int         rx_k = 0;
    logic [7:0] rx_byte = 8'h0;
    logic [9:0] frame_bits;
    int         f0;
    int         s0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        step();
        MemWrite  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (n < budget && !(sb.size() == 0 && tx_busy === 1'b0 && !rx_active)) begin
            step();
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Line receiver: start bit at k=0, each bit sampled mid-cell at k = 4*j + 2.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_k = 0;
                starts.push_back(cyc);
            end
        end else begin
            rx_k++;
            if (rx_k == 2) begin
                check("rx_start_bit", 32'(tx), 32'd0);
            end else if (rx_k >= 6 && rx_k <= 34 && ((rx_k - 2) % 4) == 0) begin
                rx_byte[(rx_k - 6) / 4] = tx;
            end else if (rx_k == 38) begin
                check("rx_stop_bit", 32'(tx), 32'd1);
                check("rx_frame_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    check("rx_byte", 32'(rx_byte), 32'(sb.pop_front()));
                end
                rx_frames++;
                rx_active = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        DataAdr = StatusAddr;
        #1;
        check("rst_status", ReadData, 32'h0);
        DataAdr = ConsoleAddr;
        #1;
        check("nonstatus_read", ReadData, 32'h0);

        // Single frame 0x41: exact latency and bit timing
        sb.push_back(8'h41);
        store(ConsoleAddr, 32'h0000_0141);
        check("t1_tx_e0", 32'(tx), 32'd1);
        step();
        check("t1_tx_e1", 32'(tx), 32'd1);
        step();
        DataAdr = StatusAddr;
        #1;
        check("t1_status_busy", ReadData, 32'h2);
        DataAdr = ConsoleAddr;
        frame_bits = {1'b1, 8'h41, 1'b0};
        for (int i = 0; i < 40; i++) begin
            check($sformatf("t1_bit%0d", i / 4), 32'(tx), 32'(frame_bits[i / 4]));
            step();
        end
        check("t1_tx_after", 32'(tx), 32'd1);
        check("t1_busy_after", 32'(tx_busy), 32'd0);
        wait_drain(100, "t1_drain");
        check("t1_frames", rx_frames, 1);

        // Nine stores while idle: the first pops at once so none overflow
        f0 = rx_frames;
        s0 = starts.size();
        for (int i = 0; i < 9; i++) begin
            sb.push_back(8'(8'h30 + i));
            store(ConsoleAddr, 32'(8'h30 + i));
            if (i == 2) check("t2_tx_low", 32'(tx), 32'd0);
        end
        check("t2_overflow", 32'(overflow), 32'd0);
        wait_drain(1000, "t2_drain");
        check("t2_frames", rx_frames - f0, 9);
        check("t2_frame_gap", starts[s0 + 1] - starts[s0], 41);
        check("t2_overflow_end", 32'(overflow), 32'd0);

        // Ten stores during a frame: eight kept, two dropped
        sb.push_back(8'h50);
        store(ConsoleAddr, 32'h50);
        step();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) sb.push_back(8'(8'h60 + i));
            store(ConsoleAddr, 32'(8'h60 + i));
        end
        check("t3_overflow", 32'(overflow), 32'd1);
        DataAdr = StatusAddr;
        #1;
        check("t3_status_full", ReadData, 32'h7);
        DataAdr = ConsoleAddr;
        wait_drain(1000, "t3_drain");
        DataAdr = StatusAddr;
        #1;
        check("t3_status_drained", ReadData, 32'h4);
        DataAdr = ConsoleAddr;
        do_reset();
        check("t3_overflow_cleared", 32'(overflow), 32'd0);

        // Halt with three bytes queued; later stores ignored; done after drain
        f0 = rx_frames;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(8'(8'h31 + i));
            store(ConsoleAddr, 32'(8'h31 + i));
        end
        Ecall = 1'b1;
        step();
        Ecall = 1'b0;
        check("t4_halted", 32'(halted), 32'd1);
        store(ConsoleAddr, 32'h99);
        check("t4_done_early", 32'(done), 32'd0);
        repeat (118) step();
        check("t4_busy_in_stop", 32'(tx_busy), 32'd1);
        step();
        check("t4_busy_idle", 32'(tx_busy), 32'd0);
        check("t4_done_not_yet", 32'(done), 32'd0);
        step();
        check("t4_done_rise", 32'(done), 32'd1);
        repeat (5) step();
        check("t4_done_sticky", 32'(done), 32'd1);
        check("t4_halted_sticky", 32'(halted), 32'd1);
        check("t4_frames", rx_frames - f0, 3);
        check("t4_sb_empty", sb.size(), 0);

        // Reset during DATA of 0x55; inputs during reset are ignored
        do_reset();
        check("t5_done_cleared", 32'(done), 32'd0);
        store(ConsoleAddr, 32'h55);
        repeat (9) step();
        check("t5_busy_mid", 32'(tx_busy), 32'd1);
        reset     = 1'b1;
        Ecall     = 1'b1;
        Ebreak    = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = ConsoleAddr;
        WriteData = 32'h77;
        step();
        reset     = 1'b0;
        Ecall     = 1'b0;
        Ebreak    = 1'b0;
        MemWrite  = 1'b0;
        check("t5_tx", 32'(tx), 32'd1);
        check("t5_busy", 32'(tx_busy), 32'd0);
        check("t5_halted", 32'(halted), 32'd0);
        f0 = rx_frames;
        sb.push_back(8'h0A);
        store(ConsoleAddr, 32'h0A);
        wait_drain(200, "t5_drain");
        check("t5_frames", rx_frames - f0, 1);

`ifdef MMIO_CONSOLE_EXIT_EN
        // Exit-code store behaves as a halt
        do_reset();
        sb.push_back(8'h21);
        store(ConsoleAddr, 32'h21);
        store(ExitAddr, 32'h2A);
        check("t6_exit_code", exit_code, 32'h2A);
        check("t6_halted", 32'(halted), 32'd1);
        for (int n = 0; n < 200 && done !== 1'b1; n++) step();
        check("t6_done", 32'(done), 32'd1);
        check("t6_sb_empty", sb.size(), 0);
`else
        // Exit address is inert without the feature
        store(ExitAddr, 32'h2A);
        check("t6_exit_inert_halted", 32'(halted), 32'd0);
        check("t6_exit_inert_busy", 32'(tx_busy), 32'd0);
`endif

        check("end_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
